// File: rtl/muldiv_seq.sv
// Sequencer for a shared radix-2 multiply/divide unit: shift-add multiply and
// restoring divide, one bit per cycle, with valid/ready request and response ports.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [1:0]       i_req_op,
  input  logic [WIDTH-1:0] i_req_a,
  input  logic [WIDTH-1:0] i_req_b,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic [WIDTH-1:0] o_resp_result,
  output logic             o_busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [1:0]         r_op;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_negate;
  logic [WIDTH-1:0]   r_result;

  logic               w_isSigned;
  logic               w_divZero;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH-1:0]   w_zeroResult;
  logic [WIDTH:0]     w_remShift;
  logic [WIDTH-2:0]   w_quoShift;
  logic               w_remGe;
  logic [WIDTH-1:0]   w_remDiff;
  logic [2*WIDTH-1:0] w_accNext;
  logic [WIDTH-1:0]   w_quotient;
  logic [WIDTH-1:0]   w_remainder;
  logic [WIDTH-1:0]   w_finalResult;

  // Request decode: magnitudes are unsigned, so |-2^(WIDTH-1)| fits without overflow.
  always_comb begin
    w_isSigned   = (i_req_op == OP_DIV) || (i_req_op == OP_REM);
    w_divZero    = (i_req_op != OP_MUL) && (i_req_b == '0);
    w_magA       = (w_isSigned && i_req_a[WIDTH-1]) ? -i_req_a : i_req_a;
    w_magB       = (w_isSigned && i_req_b[WIDTH-1]) ? -i_req_b : i_req_b;
    w_zeroResult = (i_req_op == OP_REM) ? i_req_a : '1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    o_req_ready   = 1'b0;
    o_resp_valid  = 1'b0;
    o_busy        = 1'b1;
    o_resp_result = r_result;
    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_req_valid) begin
          w_nextState = w_divZero ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_count == '0) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    if (i_flush) begin
      w_nextState = IDLE;
    end
  end

  // One iteration: multiply adds the shifted multiplicand; divide does a
  // restoring shift-subtract on {remainder, quotient}.
  always_comb begin
    w_remShift = r_acc[2*WIDTH-1:WIDTH-1];
    w_quoShift = r_acc[WIDTH-2:0];
    w_remGe    = (w_remShift >= {1'b0, r_divisor});
    w_remDiff  = w_remShift[WIDTH-1:0] - r_divisor;
    if (r_op == OP_MUL) begin
      w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    end else if (w_remGe) begin
      w_accNext = {w_remDiff, w_quoShift, 1'b1};
    end else begin
      w_accNext = {w_remShift[WIDTH-1:0], w_quoShift, 1'b0};
    end
    w_quotient  = w_accNext[WIDTH-1:0];
    w_remainder = w_accNext[2*WIDTH-1:WIDTH];
    case (r_op)
      OP_MUL:  w_finalResult = w_accNext[WIDTH-1:0];
      OP_DIV:  w_finalResult = r_negate ? -w_quotient : w_quotient;
      OP_REM:  w_finalResult = r_negate ? -w_remainder : w_remainder;
      OP_DIVU: w_finalResult = w_quotient;
      default: w_finalResult = '0;
    endcase
  end

  // The result register reads zero whenever no response is pending.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op      <= OP_MUL;
      r_count   <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_divisor <= '0;
      r_negate  <= 1'b0;
      r_result  <= '0;
    end else if (i_flush) begin
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_op      <= i_req_op;
            r_count   <= CW'(WIDTH - 1);
            r_mcand   <= {{WIDTH{1'b0}}, i_req_a};
            r_mplier  <= i_req_b;
            r_divisor <= w_magB;
            if (i_req_op == OP_MUL) begin
              r_acc <= '0;
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_magA};
            end
            case (i_req_op)
              OP_DIV:  r_negate <= i_req_a[WIDTH-1] ^ i_req_b[WIDTH-1];
              OP_REM:  r_negate <= i_req_a[WIDTH-1];
              default: r_negate <= 1'b0;
            endcase
            if (w_divZero) begin
              r_result <= w_zeroResult;
            end
          end
        end
        CALC: begin
          r_acc    <= w_accNext;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_count == '0) begin
            r_result <= w_finalResult;
          end else begin
            r_count <= r_count - CW'(1);
          end
        end
        DONE: begin
          if (i_resp_ready) begin
            r_result <= '0;
          end
        end
        default: begin
          r_result <= '0;
        end
      endcase
    end
  end

endmodule
